// File: rtl/div_prenorm_pkg.sv
// Shared types and helpers for the divider operand pre-normalisation stage.
// Unpacks packed double/single operands into a common 53-bit significand form.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } div_prenorm_state_t;

  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;
  localparam int SIG_W  = 53;
  localparam int EXP_W  = 13;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic inv;
    logic dbz;
  } div_spec_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } div_cls_t;

  typedef struct packed {
    logic        sign;
    logic [10:0] ef;
    logic [51:0] fr;
    logic        top;
  } div_op_t;

  // Single fractions are left-aligned so bit 51 is the quiet bit for both.
  function automatic div_op_t unpack_op(
    input logic [63:0] x,
    input logic        dbl
  );
    div_op_t o;
    if (dbl) begin
      o.sign = x[63];
      o.ef   = x[62:52];
      o.fr   = x[51:0];
      o.top  = &x[62:52];
    end else begin
      o.sign = x[31];
      o.ef   = {3'b000, x[30:23]};
      o.fr   = {x[22:0], 29'b0};
      o.top  = &x[30:23];
    end
    return o;
  endfunction

  function automatic div_cls_t classify(input div_op_t o);
    div_cls_t c;
    c.zero = (o.ef == '0) && (o.fr == '0);
    c.inf  = o.top && (o.fr == '0);
    c.nan  = o.top && (o.fr != '0);
    c.snan = c.nan && !o.fr[51];
    return c;
  endfunction

  function automatic logic [EXP_W-1:0] unbias(
    input div_op_t o,
    input logic    dbl
  );
    logic [EXP_W-1:0] b;
    b = dbl ? EXP_W'(BIAS_D) : EXP_W'(BIAS_S);
    if (o.ef != '0) return {2'b00, o.ef} - b;
    return EXP_W'(1) - b;
  endfunction

endpackage

// File: rtl/div_prenorm_if.sv
// Handshake and data bundle between the upstream issue logic, the
// pre-normalisation stage and the Newton-Raphson significand divider.
interface div_prenorm_if;
  import div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [63:0]      a;
  logic [63:0]      b;
  logic             db_in;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] fa;
  logic [SIG_W-1:0] fb;
  logic             db;
  logic             sq;
  logic [EXP_W-1:0] eq;
  logic             spec_nan;
  logic             spec_inf;
  logic             spec_zero;
  logic             flag_inv;
  logic             flag_dbz;

  modport master (
    output in_valid, a, b, db_in, out_ready,
    input  in_ready, out_valid, fa, fb, db, sq, eq,
    input  spec_nan, spec_inf, spec_zero, flag_inv, flag_dbz
  );

  modport slave (
    input  in_valid, a, b, db_in, out_ready,
    output in_ready, out_valid, fa, fb, db, sq, eq,
    output spec_nan, spec_inf, spec_zero, flag_inv, flag_dbz
  );

endinterface

// File: rtl/div_prenorm_shift.sv
// Per-operand significand/exponent register with coarse and fine
// left-normalisation steps.
module div_prenorm_shift
  import div_pkg::*;
#(
  parameter int SHIFT_CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [SIG_W-1:0] sig_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic [SIG_W-1:0] sig,
  output logic [EXP_W-1:0] exp_q,
  output logic             normalised
);

  assign normalised = sig[SIG_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sig   <= '0;
      exp_q <= '0;
    end else if (load) begin
      sig   <= sig_in;
      exp_q <= exp_in;
    end else if (step && !normalised) begin
      if (sig[SIG_W-1 -: SHIFT_CHUNK] == '0) begin
        sig   <= sig << SHIFT_CHUNK;
        exp_q <= exp_q - EXP_W'(SHIFT_CHUNK);
      end else begin
        sig   <= sig << 1;
        exp_q <= exp_q - EXP_W'(1);
      end
    end
  end

endmodule

// File: rtl/div_prenorm.sv
// Divider pre-normalisation stage: unpack, normalise subnormals,
// compute quotient sign/exponent and classify special operand pairs.
module div_prenorm
  import div_pkg::*;
#(
  parameter int SHIFT_CHUNK = 8
) (
  input logic         clk,
  input logic         rst,
  div_prenorm_if.slave io
);

  div_prenorm_state_t state;

  div_op_t          op_a, op_b;
  div_cls_t         ca_q, cb_q;
  div_spec_t        sp;
  logic             sq_q, db_q;
  logic             load, step, go_done, special;
  logic             norm_a, norm_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic [EXP_W-1:0] ex_a, ex_b;

  logic             ov_q, sq_o, db_o;
  logic [SIG_W-1:0] fa_o, fb_o;
  logic [EXP_W-1:0] eq_o;
  div_spec_t        sp_o;

  assign op_a = unpack_op(io.a, io.db_in);
  assign op_b = unpack_op(io.b, io.db_in);

  assign io.in_ready = (state == IDLE) && !rst;
  assign load        = io.in_valid && io.in_ready;

  always_comb begin
    sp.nan  = ca_q.nan | cb_q.nan
            | (ca_q.zero & cb_q.zero)
            | (ca_q.inf & cb_q.inf);
    sp.inv  = (ca_q.zero & cb_q.zero)
            | (ca_q.inf & cb_q.inf)
            | ca_q.snan | cb_q.snan;
    sp.dbz  = !sp.nan & !ca_q.inf & !ca_q.zero & cb_q.zero;
    sp.inf  = !sp.nan & ((ca_q.inf & !cb_q.inf) | sp.dbz);
    sp.zero = !sp.nan & ((ca_q.zero & !cb_q.zero) | (!ca_q.inf & cb_q.inf));
  end

  assign special = sp.nan | sp.inf | sp.zero;
  assign go_done = special | (norm_a & norm_b);
  assign step    = (state == NORM) && !go_done;

  div_prenorm_shift #(.SHIFT_CHUNK(SHIFT_CHUNK)) u_sh_a (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .sig_in({op_a.ef != '0, op_a.fr}),
    .exp_in(unbias(op_a, io.db_in)),
    .sig(sig_a), .exp_q(ex_a), .normalised(norm_a)
  );

  div_prenorm_shift #(.SHIFT_CHUNK(SHIFT_CHUNK)) u_sh_b (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .sig_in({op_b.ef != '0, op_b.fr}),
    .exp_in(unbias(op_b, io.db_in)),
    .sig(sig_b), .exp_q(ex_b), .normalised(norm_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ca_q  <= '0;
      cb_q  <= '0;
      sq_q  <= 1'b0;
      db_q  <= 1'b0;
      ov_q  <= 1'b0;
      sq_o  <= 1'b0;
      db_o  <= 1'b0;
      fa_o  <= '0;
      fb_o  <= '0;
      eq_o  <= '0;
      sp_o  <= '0;
    end else begin
      unique case (state)
        IDLE: if (load) begin
          state <= NORM;
          ca_q  <= classify(op_a);
          cb_q  <= classify(op_b);
          sq_q  <= op_a.sign ^ op_b.sign;
          db_q  <= io.db_in;
        end
        NORM: if (go_done) begin
          state <= DONE;
          ov_q  <= 1'b1;
          sq_o  <= sq_q;
          db_o  <= db_q;
          sp_o  <= sp;
          fa_o  <= special ? '0 : sig_a;
          fb_o  <= special ? '0 : sig_b;
          eq_o  <= special ? '0 : ex_a - ex_b;
        end
        DONE: if (io.out_ready) begin
          state <= IDLE;
          ov_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.out_valid = ov_q;
  assign io.fa        = fa_o;
  assign io.fb        = fb_o;
  assign io.eq        = eq_o;
  assign io.sq        = sq_o;
  assign io.db        = db_o;
  assign io.spec_nan  = sp_o.nan;
  assign io.spec_inf  = sp_o.inf;
  assign io.spec_zero = sp_o.zero;
  assign io.flag_inv  = sp_o.inv;
  assign io.flag_dbz  = sp_o.dbz;

endmodule

// File: tb/tb_div_prenorm.sv
// Directed bench for div_prenorm: normal, subnormal, special,
// backpressure and mid-operation reset cases.
module tb_div_prenorm;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_prenorm_if io();

  div_prenorm #(.SHIFT_CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  always #5 clk = ~clk;

  localparam logic [52:0] ONE_SIG = 53'h10000000000000;
  localparam logic [12:0] EQ_M2   = 13'h1FFE;
  localparam logic [12:0] EQ_M1074 = 13'h1BCE;
  localparam logic [12:0] EQ_M149 = 13'h1F6B;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {io.spec_nan, io.spec_inf, io.spec_zero, io.flag_inv, io.flag_dbz};
  endfunction

  task automatic send(input logic [63:0] xa, input logic [63:0] xb,
                      input logic d, output int lat);
    int n;
    n = 0;
    while (!io.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 64'(io.in_ready), 64'd1);
    io.a = xa; io.b = xb; io.db_in = d; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    logic [52:0] fa_hold;
    logic [12:0] eq_hold;
    io.in_valid = 1'b0; io.a = '0; io.b = '0;
    io.db_in = 1'b0; io.out_ready = 1'b0;

    @(posedge clk); #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd0);
    chk("rst_fa", 64'(io.fa), 64'd0);
    chk("rst_eq_flags", {io.eq, flags()}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(io.in_ready), 64'd1);

    // 6.0 / 2.0 double
    send(64'h4018000000000000, 64'h4000000000000000, 1'b1, lat);
    chk("d62_lat", 64'(lat), 64'd1);
    chk("d62_fa", 64'(io.fa), 64'(53'h18000000000000));
    chk("d62_fb", 64'(io.fb), 64'(ONE_SIG));
    chk("d62_eq", 64'(io.eq), 64'd1);
    chk("d62_sq_db", {io.sq, io.db}, 64'b01);
    chk("d62_flags", 64'(flags()), 64'd0);

    fa_hold = io.fa;
    eq_hold = io.eq;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (io.fa !== fa_hold || io.eq !== eq_hold || io.out_valid !== 1'b1 ||
          io.in_ready !== 1'b0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    release_out();
    chk("bp_release_in_ready", 64'(io.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(io.out_valid), 64'd0);

    // 1.0f / -4.0f single
    send(64'h3F800000, 64'hC0800000, 1'b0, lat);
    chk("s14_lat", 64'(lat), 64'd1);
    chk("s14_fa", 64'(io.fa), 64'(ONE_SIG));
    chk("s14_fb", 64'(io.fb), 64'(ONE_SIG));
    chk("s14_eq", 64'(io.eq), 64'(EQ_M2));
    chk("s14_sq_db", {io.sq, io.db}, 64'b10);
    release_out();

    // double min subnormal / 1.0
    send(64'h0000000000000001, 64'h3FF0000000000000, 1'b1, lat);
    chk("dsub_lat", 64'(lat), 64'd11);
    chk("dsub_fa", 64'(io.fa), 64'(ONE_SIG));
    chk("dsub_fb", 64'(io.fb), 64'(ONE_SIG));
    chk("dsub_eq", 64'(io.eq), 64'(EQ_M1074));
    release_out();

    // single min subnormal / 1.0f
    send(64'h00000001, 64'h3F800000, 1'b0, lat);
    chk("ssub_lat", 64'(lat), 64'd10);
    chk("ssub_fa", 64'(io.fa), 64'(ONE_SIG));
    chk("ssub_eq", 64'(io.eq), 64'(EQ_M149));
    release_out();

    // 1.0 / 0.0 -> inf, dbz
    send(64'h3FF0000000000000, 64'h0, 1'b1, lat);
    chk("d10_lat", 64'(lat), 64'd1);
    chk("d10_flags", 64'(flags()), 64'b01001);
    chk("d10_fa_eq", {io.fa, io.eq}, 64'd0);
    release_out();

    // 0.0 / 0.0 -> nan, invalid
    send(64'h0, 64'h0, 1'b1, lat);
    chk("d00_flags", 64'(flags()), 64'b10010);
    release_out();

    // -0.0 / 2.0 -> zero, sign set
    send(64'h8000000000000000, 64'h4000000000000000, 1'b1, lat);
    chk("dz2_flags", 64'(flags()), 64'b00100);
    chk("dz2_sq", 64'(io.sq), 64'd1);
    release_out();

    // sNaN / 1.0 -> nan, invalid
    send(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b1, lat);
    chk("snan_flags", 64'(flags()), 64'b10010);
    release_out();

    // reset in the middle of the subnormal normalisation
    io.a = 64'h1; io.b = 64'h3FF0000000000000; io.db_in = 1'b1;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (io.out_valid !== 1'b0) bad++;
    end
    chk("rst_abort_no_valid", 64'(bad), 64'd0);
    chk("rst_abort_in_ready", 64'(io.in_ready), 64'd1);

    send(64'h4018000000000000, 64'h4000000000000000, 1'b1, lat);
    chk("after_rst_lat", 64'(lat), 64'd1);
    chk("after_rst_fa", 64'(io.fa), 64'(53'h18000000000000));
    chk("after_rst_eq", 64'(io.eq), 64'd1);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_prenorm.md
# div_prenorm

Operand pre-normalisation stage for the floating-point divider. Accepts two packed IEEE-754 operands (double or single), unpacks them, normalises subnormal significands iteratively, computes quotient sign and unbiased exponent difference, and classifies special cases. Its output feeds the Newton-Raphson significand divider directly: `fa`/`fb` with the hidden bit at [52], plus `db`.

## Interface
Parameters:
- `SHIFT_CHUNK`, 8, coarse left-shift step used when the top `SHIFT_CHUNK` significand bits are all zero.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  stage can accept; high only in IDLE and not in reset
- `a`, `b`  in  64  dividend, divisor; single-precision operands occupy [31:0]
- `db_in`  in  1  1 = double, 0 = single
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `fa`, `fb`  out  53  normalised significands, hidden bit at [52]; single fraction at [51:29], [28:0] = 0
- `db`  out  1  registered precision flag
- `sq`  out  1  quotient sign, `a.sign ^ b.sign`
- `eq`  out  13  signed unbiased exponent difference `ea - eb`
- `spec_nan`, `spec_inf`, `spec_zero`  out  1 each  special result class
- `flag_inv`, `flag_dbz`  out  1 each  invalid-operation and divide-by-zero flags

## Operation
- States: IDLE, NORM, DONE.
- IDLE, on `in_valid & in_ready`:
  - Latch sign, exponent and fraction.
  - Hidden bit is 1 if the exponent field is nonzero, else 0.
  - Unbiased exponent is `E - bias` for normal operands and `1 - bias` for subnormals. Bias is 1023 for double, 127 for single.
  - Next state is NORM.
- NORM, per operand, each edge:
  - if [52] = 1: hold;
  - else if [52:45] are all zero: shift left by 8 and subtract 8 from the exponent;
  - else: shift left by 1 and subtract 1 from the exponent.
  - Both operands shift in parallel.
  - Go to DONE on the first edge where both [52] bits are set, or immediately if the pair is special. No shift occurs on that edge.
- Classification is decided in NORM and has priority over normalisation:
  - NaN: either operand NaN, 0/0, or inf/inf. `flag_inv` is set for 0/0, inf/inf, or any signalling NaN.
  - inf: inf/finite. Nonzero-finite/0 also gives inf and sets `flag_dbz`.
  - zero: 0/nonzero, or finite/inf.
  - For special results `fa` = `fb` = 0 and `eq` = 0. `sq` is still computed.
- `eq` is computed as `ea - eb` in 13-bit two's complement. The range is ±2097, so no overflow occurs.
- DONE: `out_valid` = 1 and all outputs are held stable until `out_ready`. `out_valid & out_ready` returns the block to IDLE. There is no same-cycle re-accept.

## Timing
- Reset values: state IDLE, `out_valid` 0, `in_ready` 0 during `rst` and 1 on the first cycle after. All data outputs and flags are 0.
- Accept at edge k:
  - Normal pair: `out_valid` high after edge k+1.
  - Worst case double (fraction = 1): 6×8 + 4×1 = 10 shift edges, so valid after k+11.
  - Worst case single (fraction = 1): 2×8 + 7×1 shifts, so valid after k+10.
  - Special pair: valid after k+1.
- Minimum issue interval is 3 cycles: accept, NORM, DONE/handshake.
- `rst` asserted in any state aborts the operation at that edge. Nothing is emitted.
- Backpressure: while `out_valid & !out_ready`, all outputs are frozen for any number of cycles.
- `in_valid` asserted outside IDLE is ignored. Upstream must hold it until `in_ready`.

## Structure
- Package `div_pkg` holds:
  - state enum `div_prenorm_state_t`;
  - `BIAS_D` = 1023, `BIAS_S` = 127;
  - `SIG_W` = 53, `EXP_W` = 13;
  - special-class struct `div_spec_t` {nan, inf, zero, inv, dbz}.
- Sub-module `div_prenorm_shift`: one instance per operand. It holds the 53-bit significand and 13-bit exponent registers with load/step control and outputs a `normalised` bit. The FSM and classification stay in `div_prenorm`.

## Test plan
- Double 6.0/2.0 (a = 0x4018000000000000, b = 0x4000000000000000), accept at edge k -> valid after k+1; `fa` = 53'h18000000000000, `fb` = 53'h10000000000000, `eq` = 1, `sq` = 0, no flags.
- Single 1.0f / −4.0f (0x3F800000, 0xC0800000, `db_in` = 0) -> `fa` = `fb` = 53'h10000000000000, `eq` = −2, `sq` = 1, `db` = 0.
- Double min subnormal / 1.0 (0x0000000000000001, 0x3FF0000000000000) -> valid after k+11; `fa` = 53'h10000000000000, `eq` = −1074.
- Double 1.0/0.0 -> valid after k+1; `spec_inf` = 1, `flag_dbz` = 1. Double 0.0/0.0 -> `spec_nan` = 1, `flag_inv` = 1, `flag_dbz` = 0.
- Hold `out_ready` = 0 for 5 cycles after valid -> outputs stable and `in_ready` = 0. Release -> IDLE and `in_ready` = 1 the next cycle.
- Assert `rst` for one cycle in mid-NORM during the subnormal case -> `out_valid` never rises, `in_ready` = 1 after reset, and the next normal pair completes correctly.
